// File: rtl/rr_arb_mux_if.sv
// Handshake bundle for rr_arb_mux: N valid/ready input channels and one
// registered valid/ready output channel.
interface rr_arb_mux_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int SW = $clog2(N);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SW-1:0]      out_src;
    logic               out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/rr_arb_mux.sv
// N-to-1 arbitrating multiplexer with a single registered output stage.
// MODE 0 rotates priority after every grant; MODE 1 is fixed lowest-index priority.
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = 0
) (
    input  logic        clk,
    input  logic        reset,
    rr_arb_mux_if.slave bus
);
    localparam int SW = $clog2(N);

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic [SW-1:0]      r_out_src;
    logic [SW-1:0]      r_ptr;

    logic               w_load_en;
    logic               w_any;
    logic [SW-1:0]      w_start;
    logic [2*N-1:0]     w_dbl;
    logic [SW-1:0]      w_off;
    logic [SW:0]        w_sum;
    logic [SW-1:0]      w_gidx;
    logic [SW-1:0]      w_ptr_nxt;
    logic [N-1:0]       w_grant;
    logic [WIDTH-1:0]   w_gdata;

    assign w_start   = (MODE == 1) ? '0 : r_ptr;
    assign w_load_en = !r_out_valid || bus.out_ready;
    assign w_any     = |bus.in_valid;

    // Rotating the doubled request vector puts the highest-priority channel at bit 0.
    always_comb begin
        w_dbl = {bus.in_valid, bus.in_valid} >> w_start;
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_dbl[k]) begin
                w_off = SW'(k);
            end
        end
        w_sum = {1'b0, w_start} + {1'b0, w_off};
        if (w_sum >= (SW+1)'(N)) begin
            w_sum = w_sum - (SW+1)'(N);
        end
        w_gidx = w_sum[SW-1:0];
    end

    always_comb begin
        w_grant = '0;
        w_gdata = '0;
        for (int k = 0; k < N; k++) begin
            if (w_any && (w_gidx == SW'(k))) begin
                w_grant[k] = 1'b1;
                w_gdata    = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_nxt = (w_gidx == SW'(N - 1)) ? '0 : w_gidx + SW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_ptr       <= '0;
        end else if (w_load_en) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gdata;
                r_out_src   <= w_gidx;
                if (MODE == 0) begin
                    r_ptr <= w_ptr_nxt;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_load_en ? w_grant : '0;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;
endmodule
